// File: rtl/imem_loader.sv
// imem_loader: assembles a framed big-endian byte stream into instruction words
// and writes them to instruction memory. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module imem_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int BASE_ADDR  = 0,
    parameter int DATA_WIDTH = `ISA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    // Byte handshake: a byte moves on every rising edge where rx_valid && rx_ready.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK  = 3'd7;
`endif

    localparam logic [31:0]           DEPTH = 32'(1) << ADDR_WIDTH;
    localparam logic [31:0]           LIMIT = DEPTH - 32'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic        xfer;
    logic [15:0] len_n;

    assign xfer  = rx_valid && rx_ready;
    assign len_n = {cnt_q[15:8], rx_data};

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:                    rx_ready = 1'b1;
`endif
            default:                    rx_ready = 1'b0;
        endcase
    end

    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = shift_q;
    assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign cpu_hold   = busy;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign dbg_state  = state_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    addr_d  = BASE;
                    cnt_d   = 16'h0000;
                    idx_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    cnt_d   = {rx_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    cnt_d = len_n;
                    idx_d = 2'd0;
                    if (len_n == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else if ({16'h0000, len_n} > LIMIT) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d = {shift_q[DATA_WIDTH-9:0], rx_data};
                    idx_d   = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The write pulse uses the current address; advance for the next word.
                addr_d = addr_q + ADDR_WIDTH'(1);
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            shift_q <= '0;
            cnt_q   <= 16'h0000;
            idx_q   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random framed loads checked cycle by cycle against a
// byte-position model of the frame protocol, plus literal spot checks.
module tb_imem_loader;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clock    = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_ready, imem_we, cpu_hold, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [2:0]    dbg_state;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [63:0]   exp_q[$];   // {addr, data} of each write the frame must produce
  logic [7:0]    tx_q[$];
  logic [31:0]   words[17];
  logic [31:0]   wr_data_log[$];
  logic [AW-1:0] wr_addr_log[$];

  // frame model: position of each accepted byte decides its meaning
  bit          m_active = 1'b0;
  int          m_status = 0;   // 0 none, 1 done, 2 error
  int          frame_pos = 0;
  logic [15:0] m_n = 16'h0;
  logic [7:0]  m_hi = 8'h0;
  logic [7:0]  m_csum = 8'h0;
  int          m_wr = 0;
  bit          we_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_frame(input int status);
    m_active = 1'b0;
    m_status = status;
  endtask

  // scoreboard / compare process
  always @(negedge clock) begin
    bit we_now, hs, start_ok;
    logic [7:0] b;
    int pos;
    logic [63:0] e;
    if (!reset) begin
      we_now   = we_pend;
      we_pend  = 1'b0;
      start_ok = start && !m_active;
      hs       = rx_valid && m_active && !we_now;
      chk("rx_ready", rx_ready, m_active && !we_now);
      chk("busy", busy, m_active);
      chk("cpu_hold", cpu_hold, m_active);
      chk("done", done, m_status == 1);
      chk("error", error, m_status == 2);
      chk("imem_we", imem_we, we_now);
      if (imem_we) begin
        wr_data_log.push_back(imem_wdata);
        wr_addr_log.push_back(imem_addr);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("imem_addr", 64'(imem_addr), {32'h0, e[63:32]});
          chk("imem_wdata", 64'(imem_wdata), {32'h0, e[31:0]});
        end
      end
      if (we_now) begin
        m_wr++;
        if (m_wr == int'(m_n) && !CSUM) finish_frame(1);
      end
      if (hs) begin
        b   = rx_data;
        pos = frame_pos;
        frame_pos++;
        if (pos == 0) begin
          m_hi = b;
        end else if (pos == 1) begin
          m_n = {m_hi, b};
          if (m_n == 16'h0) begin
            if (!CSUM) finish_frame(1);
          end else if (int'(m_n) > DEPTH) begin
            finish_frame(2);
          end
        end else if (pos < 2 + 4 * int'(m_n)) begin
          m_csum = m_csum ^ b;
          if ((pos - 2) % 4 == 3) we_pend = 1'b1;
        end else begin
          finish_frame((b == m_csum) ? 1 : 2);
        end
      end
      if (start_ok) begin
        m_active  = 1'b1;
        m_status  = 0;
        frame_pos = 0;
        m_csum    = 8'h00;
        m_wr      = 0;
        m_n       = 16'h0;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive_frame(input int gap_mode, input int start_at);
    int budget;
    int gap;
    for (int i = 0; i < tx_q.size(); i++) begin
      budget   = 0;
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      start    = (i == start_at);
      while (!rx_ready && budget < 20) begin
        step();
        budget++;
      end
      if (!rx_ready) begin
        chk("rx_ready_timeout", rx_ready, 1);
        rx_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      step();
      start = 1'b0;
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) step();
      end
    end
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    tx_q.delete();
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    if (n <= DEPTH) begin
      for (int w = 0; w < n; w++) begin
        for (int k = 3; k >= 0; k--) begin
          b = words[w][8*k +: 8];
          tx_q.push_back(b);
          cs = cs ^ b;
        end
        exp_q.push_back({32'(w), words[w]});
      end
      if (CSUM) tx_q.push_back(corrupt ? (cs ^ 8'h5A) : cs);
    end
  endtask

  task automatic wait_end(input int exp_status, input string name);
    int budget;
    budget = 0;
    while (m_active && budget < 400) begin
      step();
      budget++;
    end
    step();
    chk({name, "_busy"}, busy, 0);
    chk({name, "_cpu_hold"}, cpu_hold, 0);
    chk({name, "_done"}, done, exp_status == 1);
    chk({name, "_error"}, error, exp_status == 2);
    chk({name, "_writes_left"}, exp_q.size(), 0);
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    repeat (3) step();
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit corrupt, input int gap_mode, input int start_at,
                           input string name);
    int st;
    st = (n > DEPTH) ? 2 : (CSUM && corrupt) ? 2 : 1;
    build_frame(n, corrupt);
    pulse_start();
    drive_frame(gap_mode, start_at);
    wait_end(st, name);
  endtask

  task automatic randomize_words();
    for (int i = 0; i < 17; i++) words[i] = $urandom;
  endtask

  initial begin
    int base;
    int n;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_imem_addr", 64'(imem_addr), 0);
    chk("rst_imem_wdata", 64'(imem_wdata), 0);
    reset = 1'b0;
    step();

    // basic load, rx_valid held high
    words[0] = 32'h12345678;
    words[1] = 32'hDEADBEEF;
    base = wr_data_log.size();
    run_frame(2, 1'b0, 0, -1, "basic");
    chk("basic_w0_data", wr_data_log[base], 32'h12345678);
    chk("basic_w0_addr", 64'(wr_addr_log[base]), 0);
    chk("basic_w1_data", wr_data_log[base+1], 32'hDEADBEEF);
    chk("basic_w1_addr", 64'(wr_addr_log[base+1]), 1);

    // same frame with rx_valid toggling, and an ignored start mid-frame
    base = wr_data_log.size();
    run_frame(2, 1'b0, 1, 3, "gaps");
    chk("gaps_w0_data", wr_data_log[base], 32'h12345678);
    chk("gaps_w1_data", wr_data_log[base+1], 32'hDEADBEEF);

    run_frame(0, 1'b0, 0, -1, "zero_len");

    // overflow, then recovery
    run_frame(17, 1'b0, 0, -1, "overflow17");
    run_frame(256, 1'b0, 1, -1, "overflow256");
    randomize_words();
    run_frame(16, 1'b0, 0, -1, "full_depth");
    chk("full_depth_last_addr", 64'(wr_addr_log[wr_addr_log.size()-1]), 15);

    // reset after the 2nd data byte of the first word
    randomize_words();
    build_frame(2, 1'b0);
    while (tx_q.size() > 4) void'(tx_q.pop_back());
    pulse_start();
    drive_frame(0, -1);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_rx_ready", rx_ready, 0);
    chk("midrst_imem_we", imem_we, 0);
    chk("midrst_cpu_hold", cpu_hold, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_imem_addr", 64'(imem_addr), 0);
    chk("midrst_imem_wdata", 64'(imem_wdata), 0);
    m_active = 1'b0;
    m_status = 0;
    we_pend  = 1'b0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
    randomize_words();
    run_frame(3, 1'b0, 2, -1, "after_reset");

`ifdef LOADER_CHECKSUM_EN
    words[0] = 32'h11223344;
    base = wr_data_log.size();
    run_frame(1, 1'b0, 0, -1, "csum_ok");
    chk("csum_ok_data", wr_data_log[base], 32'h11223344);
    tx_q.delete();
    tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    tx_q.push_back(8'h00);
    exp_q.push_back({32'h0, 32'h11223344});
    base = wr_data_log.size();
    pulse_start();
    drive_frame(0, -1);
    wait_end(2, "csum_bad");
    chk("csum_bad_data", wr_data_log[base], 32'h11223344);
    chk("csum_bad_addr", 64'(wr_addr_log[base]), 0);
`endif

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      randomize_words();
      n = $urandom_range(0, 17);
      run_frame(n, CSUM ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 2),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads from.
- Receives a framed byte stream (from the UART receiver) with a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the prgrom write port at sequential word addresses.
- Holds the CPU core in reset while loading; signals done or error when the frame ends.

Parameters:
- ADDR_WIDTH, 14, word-address width of instruction memory (matches PC[15:2]); capacity DEPTH = 2**ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written.
- DATA_WIDTH, `ISA_WIDTH (32), instruction word width; fixed at 4 bytes per word.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load frame (honoured only in IDLE, DONE or ERROR).
- rx_valid  input  1  byte available on rx_data.
- rx_data  input  8  received byte.
- rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready.
- imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  DATA_WIDTH  instruction word for the write.
- cpu_hold  output  1  held high from accepted start until DONE/ERROR; OR'd into the core reset.
- busy  output  1  high in any state other than IDLE, DONE, ERROR.
- done  output  1  level, high in DONE.
- error  output  1  level, high in ERROR.

Behaviour:
- Reset (asynchronous): state IDLE; rx_ready, imem_we, cpu_hold, busy, done, error = 0; imem_addr = BASE_ADDR; imem_wdata = 0; internal word count, byte index and shift register = 0.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, first byte = bits 31:24.
- States:
  - IDLE: on start -> LEN_HI, cpu_hold = 1, imem_addr = BASE_ADDR.
  - LEN_HI: rx_ready = 1; on transfer, latch the byte as N[15:8] -> LEN_LO.
  - LEN_LO: rx_ready = 1; on transfer, latch N[7:0].
    - N == 0 -> DONE.
    - N > DEPTH - BASE_ADDR -> ERROR.
    - Otherwise -> DATA, byte index = 0.
  - DATA: rx_ready = 1; on transfer, shift register = {shift[23:0], rx_data} and the byte index increments. On the 4th byte -> WRITE.
  - WRITE: rx_ready = 0. For exactly one cycle, imem_we = 1 and imem_wdata = assembled word at the current imem_addr.
    - Next cycle: imem_addr increments and the remaining count decrements.
    - If the remaining count reaches 0 -> DONE (or CHECK with the option), else -> DATA.
  - DONE: cpu_hold = 0, done = 1; start -> LEN_HI and clears done.
  - ERROR: cpu_hold = 0, error = 1; start -> LEN_HI and clears error.
- Latency: imem_we asserts the cycle after the 4th byte of a word is accepted. Sustained rate is one word per 5 cycles with rx_valid held high.
- Address arithmetic: imem_addr is ADDR_WIDTH wide. The length check guarantees no wrap; the last write is at BASE_ADDR + N - 1.
- Ignored inputs:
  - start while busy is ignored; the frame continues.
  - rx_valid in IDLE/DONE/ERROR is ignored (rx_ready = 0, no byte consumed).
- Reset mid-frame: immediate return to IDLE with outputs at reset values. The partial word is discarded; no further write pulse.
- done and error are never high simultaneously. imem_we is never high outside WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the FSM enters CHECK with rx_ready = 1 and consumes one trailing byte.
  - The expected checksum is the XOR of all data bytes, accumulated during DATA and cleared at start.
  - Match -> DONE; mismatch -> ERROR. The memory contents already written remain as written.
  - With N == 0 the checksum byte is still consumed and compared against 0x00.
- Undefined: no CHECK state, no accumulator; the last WRITE goes directly to DONE.

Test Plan:
- Basic load: start, bytes 00 02 12 34 56 78 DE AD BE EF, rx_valid held high.
  - Required: writes 0x12345678 @0 and 0xDEADBEEF @1.
  - Required: done = 1, cpu_hold falls on the same cycle, busy = 0.
- Backpressure/gaps: same frame with rx_valid toggling every other cycle.
  - Required: identical writes.
  - Required: no write pulse while a word is incomplete; rx_ready = 0 during each WRITE cycle.
- Zero length: start, 00 00.
  - Required: DONE two transfers after start, no imem_we pulse (with LOADER_CHECKSUM_EN, also send 00 -> DONE).
- Overflow: ADDR_WIDTH = 4, start, 00 11 (17 > 16).
  - Required: ERROR, error = 1, no write; a following start plus a valid frame recovers to DONE.
- Reset mid-frame: assert reset after the 2nd data byte of the first word.
  - Required: all outputs at reset values asynchronously, no write occurs, a fresh frame loads correctly.
- Checksum (LOADER_CHECKSUM_EN):
  - Frame 00 01 11 22 33 44 + 44 -> DONE.
  - Same frame + 00 -> ERROR, with 0x11223344 still written @0.
